// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage: bus structs,
// fetch FSM states and the reset PC.
package fetch_unit_pkg;

  typedef logic [63:0] addr_t;

  localparam addr_t PC_RESET_DEFAULT = 64'h0000_0000_8000_0000;
  localparam addr_t INSTR_BYTES      = 64'd4;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic  valid;
    addr_t addr;
  } ibus_req_t;

  typedef struct packed {
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

endpackage

// File: rtl/fetch_unit_pc_gen.sv
// Next-PC select for the fetch stage: sequential pc+4 or the execute redirect,
// plus a flag when the chosen PC is not word aligned.
module fetch_unit_pc_gen
  import fetch_unit_pkg::*;
(
  input  logic [63:0] cur_pc,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic [63:0] next_pc,
  output logic        misaligned
);

  always_comb begin
    next_pc    = redirect_valid ? redirect_pc : (cur_pc + INSTR_BYTES);
    misaligned = (next_pc[1:0] != 2'b00);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding word request, captured into a
// HOLD register presented to the decoder via valid/ready.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [63:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  input  logic        out_ready,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        fetch_err,
  output logic [63:0] instret
);

  fetch_state_e state_q, state_d;
  addr_t        pc_q, pc_d;
  addr_t        out_pc_q, out_pc_d;
  addr_t        instret_q, instret_d;
  logic [31:0]  out_instr_q, out_instr_d;
  logic         fetch_err_q, fetch_err_d;

  ibus_req_t    ireq;
  ibus_resp_t   iresp;
  addr_t        next_pc;
  logic         next_misaligned;

  assign iresp = '{data_ok: iresp_data_ok, data: iresp_data};

  // The sequential PC is derived from the held instruction's PC.
  fetch_unit_pc_gen u_pc_gen (
    .cur_pc         (out_pc_q),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .next_pc        (next_pc),
    .misaligned     (next_misaligned)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_FETCH;
      pc_q        <= PC_RESET;
      out_pc_q    <= '0;
      out_instr_q <= '0;
      instret_q   <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      instret_q   <= instret_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    instret_d   = instret_q;
    fetch_err_d = fetch_err_q;
    ireq.valid  = 1'b0;
    ireq.addr   = pc_q;

    case (state_q)
      ST_FETCH: begin
        ireq.valid = 1'b1;
        if (iresp.data_ok) begin
          out_instr_d = iresp.data;
          out_pc_d    = pc_q;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          instret_d = instret_q + 64'd1;
          pc_d      = next_pc;
          // A misaligned target is recorded but never put on the bus.
          if (next_misaligned) begin
            state_d     = ST_HALT;
            fetch_err_d = 1'b1;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d     = ST_HALT;
        fetch_err_d = 1'b1;
      end
    endcase
  end

  assign ireq_valid = ireq.valid;
  assign ireq_addr  = ireq.addr;
  assign out_valid  = (state_q == ST_HOLD);
  assign out_instr  = out_instr_q;
  assign out_pc     = out_pc_q;
  assign fetch_err  = fetch_err_q;
  assign instret    = instret_q;

endmodule
